regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the backend writeback stage, successor to the fixed 2-read/1-write file. It provides NRD combinational read ports and NWR write ports with same-cycle write-to-read bypass and deterministic write-port priority. Storage is initialised by a post-reset clear sequencer rather than a parallel reset. An optional scoreboard tracks registers with in-flight producers. Entry 0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of 2, ≥4)
- NRD, 2, number of read ports (≥1)
- NWR, 1, number of write ports (≥1)
- AW, $clog2(NREGS), address width (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR×AW  per-port write address
- wr_data  in  NWR×XLEN  per-port write data
- rd_addr  in  NRD×AW  per-port read address
- rd_data  out  NRD×XLEN  per-port read data (combinational)
- ready  out  1  high once the clear sequence is complete
- rsv_en  in  1  scoreboard reserve strobe (REGFILE_SCOREBOARD_EN only)
- rsv_addr  in  AW  register being reserved (REGFILE_SCOREBOARD_EN only)
- rd_busy  out  NRD  per-read-port pending flag (REGFILE_SCOREBOARD_EN only)

## Operation
- FSM states: CLEAR, READY. Reset forces CLEAR with clear pointer = 1.
- CLEAR: writes zero to entry[ptr] and increments ptr each cycle. After writing NREGS-1, moves to READY.
- CLEAR: all wr_en are ignored, rd_data = 0, ready = 0.
- READY: ready = 1. The FSM stays in READY until reset.
- Write, READY only: for each port p with wr_en[p] and wr_addr[p] ≠ 0, entry[wr_addr[p]] ← wr_data[p] at the clock edge.
- Write conflict: when ports collide on one address, the highest-index enabled port wins for storage and bypass.
- Read port r, evaluated in order:
  - rd_addr[r] = 0 → 0.
  - Otherwise, an enabled write port to the same address (highest index wins) → that port's wr_data (bypass).
  - Otherwise → entry[rd_addr[r]].
- Writes to address 0 are discarded and never bypassed.

## Timing
- Reset values: ready = 0, rd_data = 0, rd_busy = 0, FSM = CLEAR, ptr = 1, all busy bits = 0.
- Clear duration: exactly NREGS-1 cycles after reset deasserts. ready rises on cycle NREGS-1 (31 for NREGS = 32).
- Reset asserted mid-clear or in READY: restarts CLEAR from ptr = 1. Partially cleared contents are not trusted.
- Read latency: 0 cycles (combinational from rd_addr, wr_*).
- Write latency: visible through bypass in the same cycle, and from storage on the next cycle.
- The clear pointer is AW+1 bits wide, so wrap-around cannot occur before the terminal compare.

## Configuration
- REGFILE_SCOREBOARD_EN defined:
  - Adds a busy[NREGS] vector and the rsv_en/rsv_addr/rd_busy ports.
  - rsv_en with rsv_addr ≠ 0 sets busy[rsv_addr].
  - An accepted write clears busy[wr_addr].
  - Reserve and write to the same address in one cycle: reserve wins and busy stays 1 (a new producer is in flight).
  - rd_busy[r] = busy[rd_addr[r]] & ~(same-cycle accepted write to that address & no same-cycle reserve of it).
  - busy[0] is always 0. Busy bits are cleared by reset and held 0 during CLEAR.
- REGFILE_SCOREBOARD_EN undefined: busy logic and the three ports are absent. The file is a pure storage/bypass block.

## Structure
- regfile_pkg holds:
  - the default XLEN/NREGS/NRD/NWR localparams;
  - the rf_state_e enum {CLEAR, READY};
  - a function computing the winning write port for a given address (shared by the storage and bypass paths).
- Sub-module regfile_clear_seq holds the CLEAR/READY FSM and pointer. It outputs clr_we, clr_addr and ready to the parent.

## Test plan
- Reset, NREGS = 32: ready = 0 for cycles 0–30 and rises at cycle 31; rd_data = 0 throughout; a write to x3 during CLEAR is dropped (x3 reads 0 afterwards).
- READY, write x5 = 0xDEADBEEF with rd_addr[0] = 5 in the same cycle → rd_data[0] = 0xDEADBEEF (bypass); next cycle rd_data[0] = 0xDEADBEEF from storage.
- Write x0 = 0xFFFFFFFF with rd_addr[1] = 0 → rd_data[1] = 0 in that cycle and all later cycles.
- NWR = 2, port0 writes x7 = 0x11, port1 writes x7 = 0x22 in the same cycle → same-cycle read returns 0x22, stored value is 0x22.
- Write x9 = 0xA5A5A5A5, then assert reset for 1 cycle → ready drops; after 31 cycles x9 reads 0.
- With REGFILE_SCOREBOARD_EN, reserve x4:
  - next cycle rd_busy = 1 for reads of x4;
  - a write to x4 → rd_busy = 0 in that cycle;
  - simultaneous reserve + write to x4 → busy stays 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default sizes, clear FSM state type and write-port arbitration for regfile_mp
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;
    localparam int DEF_NWR   = 1;

    // Arbitration operates on fixed-width vectors so one function serves every port count.
    localparam int MAX_WR = 8;
    localparam int MAX_AW = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    typedef struct packed {
        logic                      hit;
        logic [$clog2(MAX_WR)-1:0] port;
    } wr_sel_t;

    function automatic wr_sel_t wr_winner(
        input logic [MAX_WR-1:0]             en,
        input logic [MAX_WR-1:0][MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0]             a
    );
        wr_sel_t s;
        s = '0;
        if (a != '0) begin
            for (int p = 0; p < MAX_WR; p++) begin
                if (en[p] && addr[p] == a) begin
                    s.hit  = 1'b1;
                    s.port = ($clog2(MAX_WR))'(p);
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - regfile_mp port bundle; rsv_en/rsv_addr/rd_busy exist only with REGFILE_SCOREBOARD_EN
interface regfile_mp_if #(
    parameter int XLEN  = regfile_pkg::DEF_XLEN,
    parameter int NREGS = regfile_pkg::DEF_NREGS,
    parameter int NRD   = regfile_pkg::DEF_NRD,
    parameter int NWR   = regfile_pkg::DEF_NWR
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic                     ready;

`ifdef REGFILE_SCOREBOARD_EN
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic [NRD-1:0]           rd_busy;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
                    input  rd_data, ready, rd_busy);
    modport slave  (input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
                    output rd_data, ready, rd_busy);
`else
    modport master (output wr_en, wr_addr, wr_data, rd_addr,
                    input  rd_data, ready);
    modport slave  (input  wr_en, wr_addr, wr_data, rd_addr,
                    output rd_data, ready);
`endif

endinterface

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset clear sequencer: zeroes entries 1..NREGS-1, then holds READY
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    rf_state_e   state;
    logic [AW:0] ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= (AW+1)'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == (AW+1)'(NREGS-1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = ptr[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NRD-read/NWR-write register file with same-cycle bypass and x0 hardwired to zero
// Optional busy scoreboard enabled by REGFILE_SCOREBOARD_EN; supports NWR <= 8, NREGS <= 256.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    parameter int NWR   = DEF_NWR,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic        clk,
    input  logic        reset,
    regfile_mp_if.slave bus
);

    logic                            clr_we;
    logic [AW-1:0]                   clr_addr;
    logic                            ready;
    logic [MAX_WR-1:0]               en_ext;
    logic [MAX_WR-1:0][MAX_AW-1:0]   addr_ext;
    logic [MAX_WR-1:0][XLEN-1:0]     data_ext;
    logic [XLEN-1:0]                 mem [NREGS];
    wr_sel_t                         ent_sel [NREGS];
    wr_sel_t                         rd_sel [NRD];

    regfile_clear_seq #(.NREGS(NREGS)) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign bus.ready = ready;

    // Write enables are masked until the clear sequence finishes.
    always_comb begin
        en_ext   = '0;
        addr_ext = '0;
        data_ext = '0;
        for (int p = 0; p < NWR; p++) begin
            en_ext[p]   = bus.wr_en[p] & ready;
            addr_ext[p] = MAX_AW'(bus.wr_addr[p]);
            data_ext[p] = bus.wr_data[p];
        end
    end

    always_comb begin
        for (int e = 0; e < NREGS; e++) begin
            ent_sel[e] = wr_winner(en_ext, addr_ext, MAX_AW'(e));
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int e = 1; e < NREGS; e++) begin
                if (ent_sel[e].hit) mem[e] <= data_ext[ent_sel[e].port];
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_sel[r] = wr_winner(en_ext, addr_ext, MAX_AW'(bus.rd_addr[r]));
            if (!ready || bus.rd_addr[r] == '0) bus.rd_data[r] = '0;
            else if (rd_sel[r].hit)             bus.rd_data[r] = data_ext[rd_sel[r].port];
            else                                bus.rd_data[r] = mem[bus.rd_addr[r]];
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] rsv_hit;

    always_comb begin
        for (int e = 0; e < NREGS; e++) begin
            rsv_hit[e] = bus.rsv_en && (e != 0) && (bus.rsv_addr == AW'(e));
        end
    end

    // A reserve outranks a same-cycle write: the new producer is still in flight.
    always_ff @(posedge clk) begin
        if (reset || !ready) begin
            busy <= '0;
        end else begin
            for (int e = 1; e < NREGS; e++) begin
                if (rsv_hit[e])          busy[e] <= 1'b1;
                else if (ent_sel[e].hit) busy[e] <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            bus.rd_busy[r] = busy[bus.rd_addr[r]] & ~(rd_sel[r].hit & ~rsv_hit[bus.rd_addr[r]]);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (NWR=2, NRD=2) against an array-based model
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic                     ready;
        logic [NRD-1:0][XLEN-1:0] rd;
        logic [NRD-1:0]           busy;
    } exp_t;

    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_busy [NREGS];
    int              m_cnt;
    bit              m_ready;
    logic            rsv_en_v;
    logic [AW-1:0]   rsv_addr_v;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t predict();
        exp_t x;
        x = '0;
        x.ready = m_ready;
        for (int r = 0; r < NRD; r++) begin
            int              a;
            logic [XLEN-1:0] v;
            bit              wh;
            a  = int'(bus.rd_addr[r]);
            v  = '0;
            wh = 0;
            if (m_ready && a != 0) begin
                v = m_mem[a];
                for (int p = 0; p < NWR; p++) begin
                    if (bus.wr_en[p] && int'(bus.wr_addr[p]) == a) begin
                        v  = bus.wr_data[p];
                        wh = 1;
                    end
                end
            end
            x.rd[r]   = v;
            x.busy[r] = m_busy[a] && !(wh && !(rsv_en_v && int'(rsv_addr_v) == a));
        end
        return x;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int a = 0; a < NREGS; a++) begin
                m_mem[a]  = '0;
                m_busy[a] = 0;
            end
            m_cnt   = 0;
            m_ready = 0;
        end else if (!m_ready) begin
            m_cnt++;
            m_ready = (m_cnt == NREGS - 1);
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.wr_en[p] && bus.wr_addr[p] != '0) begin
                    m_mem[bus.wr_addr[p]]  = bus.wr_data[p];
                    m_busy[bus.wr_addr[p]] = 0;
                end
            end
            if (rsv_en_v && rsv_addr_v != '0) m_busy[rsv_addr_v] = 1;
        end
    endtask

    task automatic cyc(input logic rst, input logic [NWR-1:0] we,
                       input int wa0, input logic [XLEN-1:0] wd0,
                       input int wa1, input logic [XLEN-1:0] wd1,
                       input int ra0, input int ra1,
                       input logic rv, input int rva);
        reset          = rst;
        bus.wr_en      = we;
        bus.wr_addr[0] = AW'(wa0);
        bus.wr_data[0] = wd0;
        bus.wr_addr[1] = AW'(wa1);
        bus.wr_data[1] = wd1;
        bus.rd_addr[0] = AW'(ra0);
        bus.rd_addr[1] = AW'(ra1);
        rsv_en_v       = rv;
        rsv_addr_v     = AW'(rva);
`ifdef REGFILE_SCOREBOARD_EN
        bus.rsv_en     = rv;
        bus.rsv_addr   = AW'(rva);
`endif
        q.push_back(predict());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t x;
                x = q.pop_front();
                chk("ready", XLEN'(bus.ready), XLEN'(x.ready));
                chk("rd_data0", bus.rd_data[0], x.rd[0]);
                chk("rd_data1", bus.rd_data[1], x.rd[1]);
`ifdef REGFILE_SCOREBOARD_EN
                chk("rd_busy", XLEN'(bus.rd_busy), XLEN'(x.busy));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        bus.wr_en  = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        rsv_en_v   = 1'b0;
        rsv_addr_v = '0;
`ifdef REGFILE_SCOREBOARD_EN
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
`endif
        for (int a = 0; a < NREGS; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 0;
        end
        m_cnt   = 0;
        m_ready = 0;
        @(posedge clk);
        #1;

        cyc(1, 2'b01, 3, 32'h1234, 0, 0, 3, 5, 0, 0);
        // Clear phase: writes to x3 must be dropped and ready must stay low for 31 cycles.
        for (int i = 0; i < NREGS; i++) cyc(0, 2'b01, 3, 32'h1234_0000 + i, 0, 0, 3, 1, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0);

        cyc(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 5, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 5, 0, 0, 0);
        cyc(0, 2'b10, 0, 0, 0, 32'hFFFFFFFF, 5, 0, 0, 0);
        cyc(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 2'b11, 7, 32'h11, 7, 32'h22, 7, 7, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 7, 5, 0, 0);

        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4);
        cyc(0, 2'b00, 0, 0, 0, 0, 4, 5, 0, 0);
        cyc(0, 2'b01, 4, 32'h44, 0, 0, 4, 4, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4);
        cyc(0, 2'b10, 0, 0, 4, 32'h55, 4, 0, 1, 4);
        cyc(0, 2'b00, 0, 0, 0, 0, 4, 4, 0, 0);

        cyc(0, 2'b01, 9, 32'hA5A5A5A5, 0, 0, 9, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 9, 7, 0, 0);
        cyc(1, 2'b00, 0, 0, 0, 0, 9, 7, 0, 0);
        for (int i = 0; i < NREGS + 1; i++) cyc(0, 2'b00, 0, 0, 0, 0, 9, 7, 0, 0);

        for (int i = 0; i < 900; i++) begin
            int a[5];
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, 3) != 0) a[k] = int'($urandom_range(0, 7));
                else                           a[k] = int'($urandom_range(0, NREGS - 1));
            end
            cyc(($urandom_range(0, 299) == 0), 2'($urandom),
                a[0], $urandom, a[1], $urandom, a[2], a[3],
                ($urandom_range(0, 3) == 0), a[4]);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
